// File: rtl/mips_ins_pkg.sv
// Shared MIPS instruction-word layout: field bit positions and widths.
package mips_ins_pkg;
  localparam int INS_W    = 32;
  localparam int OP_HI    = 31;
  localparam int RS_HI    = 25;
  localparam int RT_HI    = 20;
  localparam int RD_HI    = 15;
  localparam int SA_HI    = 10;
  localparam int FUNCT_HI = 5;
  localparam int IMM_W    = 16;
  localparam int JT_W     = 26;
  localparam int OP_W     = 6;
  localparam int REG_W    = 5;
  localparam int FUNCT_W  = 6;
endpackage

// File: rtl/ins_field_split.sv
// Combinational split of a MIPS word into its fields; zero forces every field to 0.
module ins_field_split
  import mips_ins_pkg::*;
(
  input  logic [INS_W-1:0]   ins,
  input  logic               zero,
  output logic [OP_W-1:0]    op_code,
  output logic [REG_W-1:0]   rs_reg,
  output logic [REG_W-1:0]   rt_reg,
  output logic [REG_W-1:0]   rd_reg,
  output logic [REG_W-1:0]   sa_number,
  output logic [FUNCT_W-1:0] funct,
  output logic [IMM_W-1:0]   imm_number,
  output logic [JT_W-1:0]    jump_target
);
  logic [INS_W-1:0] w;

  assign w           = zero ? '0 : ins;
  assign op_code     = w[OP_HI -: OP_W];
  assign rs_reg      = w[RS_HI -: REG_W];
  assign rt_reg      = w[RT_HI -: REG_W];
  assign rd_reg      = w[RD_HI -: REG_W];
  assign sa_number   = w[SA_HI -: REG_W];
  assign funct       = w[FUNCT_HI -: FUNCT_W];
  assign imm_number  = w[IMM_W-1:0];
  assign jump_target = w[JT_W-1:0];
endmodule

// File: rtl/ir_fetch_queue.sv
// Instruction fetch FIFO: buffers fetched words with their PC and exposes the
// decoded fields of the head entry. Flush discards everything for taken branches.
module ir_fetch_queue
  import mips_ins_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                Flush,
  input  logic                In_valid,
  output logic                In_ready,
  input  logic [INS_W-1:0]    In_ins,
  input  logic [PC_W-1:0]     In_pc,
  output logic                Out_valid,
  input  logic                Out_ready,
  output logic [PC_W-1:0]     Out_pc,
  output logic [OP_W-1:0]     Op_code,
  output logic [REG_W-1:0]    Rs_reg,
  output logic [REG_W-1:0]    Rt_reg,
  output logic [REG_W-1:0]    Rd_reg,
  output logic [REG_W-1:0]    Sa_number,
  output logic [FUNCT_W-1:0]  Funct,
  output logic [IMM_W-1:0]    Imm_number,
  output logic [JT_W-1:0]     Jump_target,
  output logic [CNT_W-1:0]    Count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PC_W+INS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      cnt;
  logic                  empty, full, push, pop;
  logic [PC_W+INS_W-1:0] head;

  assign empty     = (cnt == '0);
  assign full      = (cnt == FULL_CNT);
  assign In_ready  = !full;
  assign Out_valid = !empty;
  assign Count     = cnt;
  assign push      = In_valid && In_ready;
  assign pop       = Out_valid && Out_ready;

  // Flush outranks both handshakes: pointers and count return to zero.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (Flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      cnt <= cnt + CNT_W'(1);
      else if (pop && !push) cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !Flush) mem[wr_ptr] <= {In_pc, In_ins};
  end

  assign head   = mem[rd_ptr];
  assign Out_pc = empty ? '0 : head[PC_W+INS_W-1:INS_W];

  ins_field_split u_split (
    .ins         (head[INS_W-1:0]),
    .zero        (empty),
    .op_code     (Op_code),
    .rs_reg      (Rs_reg),
    .rt_reg      (Rt_reg),
    .rd_reg      (Rd_reg),
    .sa_number   (Sa_number),
    .funct       (Funct),
    .imm_number  (Imm_number),
    .jump_target (Jump_target)
  );
endmodule

// File: tb/tb_ir_fetch_queue.sv
// Bench for ir_fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_ir_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             CLK = 0, Reset = 1, Flush = 0, In_valid = 0, Out_ready = 0;
  logic [31:0]      In_ins = 0;
  logic [PC_W-1:0]  In_pc = 0;
  logic             In_ready, Out_valid;
  logic [PC_W-1:0]  Out_pc;
  logic [5:0]       Op_code, Funct;
  logic [4:0]       Rs_reg, Rt_reg, Rd_reg, Sa_number;
  logic [15:0]      Imm_number;
  logic [25:0]      Jump_target;
  logic [CNT_W-1:0] Count;

  int vectors = 0, miscompares = 0;
  logic [63:0] q[$];   // model: {pc, ins}, front is head

  ir_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .CLK(CLK), .Reset(Reset), .Flush(Flush), .In_valid(In_valid), .In_ready(In_ready),
    .In_ins(In_ins), .In_pc(In_pc), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Out_pc(Out_pc), .Op_code(Op_code), .Rs_reg(Rs_reg), .Rt_reg(Rt_reg), .Rd_reg(Rd_reg),
    .Sa_number(Sa_number), .Funct(Funct), .Imm_number(Imm_number),
    .Jump_target(Jump_target), .Count(Count)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (!Reset) assert (int'(Count) <= DEPTH);

  // Advance one clock, updating the model from the inputs presented before the edge.
  task automatic tick();
    bit do_push, do_pop;
    do_push = In_valid && (q.size() < DEPTH);
    do_pop  = Out_ready && (q.size() > 0);
    @(posedge CLK);
    #1;
    if (Flush) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({In_pc, In_ins});
    end
  endtask

  task automatic push_word(input logic [31:0] w, input logic [31:0] pc);
    In_valid = 1; In_ins = w; In_pc = pc;
    tick();
    In_valid = 0;
  endtask

  task automatic test_reset();
    Reset = 1; #2;
    vectors++; if (Count !== 0 || Out_valid !== 0 || In_ready !== 1) begin
      miscompares++; $display("FAIL reset_initial cnt=%0d ov=%b ir=%b want 0/0/1", Count, Out_valid, In_ready); end
    @(negedge CLK); Reset = 0; q.delete();
    @(posedge CLK); #1;
    push_word(32'h8C220004, 32'h0);
    push_word(32'h00430820, 32'h4);
    #2 Reset = 1; #1;
    vectors++; if (Count !== 0 || Out_valid !== 0 || Op_code !== 0 || In_ready !== 1 || Out_pc !== 0) begin
      miscompares++; $display("FAIL reset_mid cnt=%0d ov=%b op=%h ir=%b pc=%h want 0/0/0/1/0",
                              Count, Out_valid, Op_code, In_ready, Out_pc); end
    q.delete();
    @(negedge CLK); Reset = 0;
    @(posedge CLK); #1;
  endtask

  task automatic test_fill_decode();
    Out_ready = 0;
    push_word(32'h8C220004, 32'h0);
    push_word(32'h00430820, 32'h4);
    push_word(32'h08000010, 32'h8);
    push_word(32'h20010005, 32'hC);
    vectors++; if (In_ready !== 0 || Count !== 4) begin
      miscompares++; $display("FAIL fill_full ir=%b cnt=%0d want 0/4", In_ready, Count); end
    vectors++; if (Op_code !== 6'h23 || Rs_reg !== 1 || Rt_reg !== 2 || Imm_number !== 16'h4 || Out_pc !== 0) begin
      miscompares++; $display("FAIL fill_head op=%h rs=%0d rt=%0d imm=%h pc=%h want 23/1/2/0004/0",
                              Op_code, Rs_reg, Rt_reg, Imm_number, Out_pc); end
    push_word(32'hDEADBEEF, 32'h10);
    vectors++; if (Count !== 4 || Op_code !== 6'h23 || q.size() != 4) begin
      miscompares++; $display("FAIL full_refuse cnt=%0d op=%h want 4/23", Count, Op_code); end
  endtask

  task automatic test_drain();
    Out_ready = 1;
    tick();
    vectors++; if (Rd_reg !== 1 || Funct !== 6'h20 || Out_pc !== 32'h4) begin
      miscompares++; $display("FAIL drain_1 rd=%0d funct=%h pc=%h want 1/20/4", Rd_reg, Funct, Out_pc); end
    tick();
    vectors++; if (Jump_target !== 26'h10 || Op_code !== 6'h02) begin
      miscompares++; $display("FAIL drain_2 jt=%h op=%h want 0000010/02", Jump_target, Op_code); end
    tick();
    vectors++; if (Op_code !== 6'h08 || Count !== 1) begin
      miscompares++; $display("FAIL drain_3 op=%h cnt=%0d want 08/1", Op_code, Count); end
    tick();
    vectors++; if (Out_valid !== 0 || Count !== 0 || Op_code !== 0 || Imm_number !== 0 ||
                   Jump_target !== 0 || Out_pc !== 0) begin
      miscompares++; $display("FAIL drain_empty ov=%b cnt=%0d op=%h imm=%h jt=%h pc=%h want all 0",
                              Out_valid, Count, Op_code, Imm_number, Jump_target, Out_pc); end
    Out_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    w = 32'h1000_0000;
    push_word(w, 32'h100);
    Out_ready = 1; In_valid = 1;
    for (int i = 0; i < 20; i++) begin
      w = w + 1; In_ins = w; In_pc = 32'h100 + 4 * (i + 1);
      tick();
      vectors++; if (Count !== 1 || Out_valid !== 1 || {Op_code, Rs_reg, Rt_reg, Imm_number} !== w ||
                     Out_pc !== In_pc) begin
        miscompares++; $display("FAIL b2b_%0d cnt=%0d ov=%b word=%h pc=%h want 1/1/%h/%h",
                                i, Count, Out_valid, {Op_code, Rs_reg, Rt_reg, Imm_number}, Out_pc, w, In_pc); end
    end
    In_valid = 0;
    tick();
    Out_ready = 0;
  endtask

  task automatic test_flush();
    push_word(32'h11111111, 32'h200);
    push_word(32'h22222222, 32'h204);
    push_word(32'h33333333, 32'h208);
    vectors++; if (Count !== 3) begin
      miscompares++; $display("FAIL flush_pre cnt=%0d want 3", Count); end
    Flush = 1; In_valid = 1; Out_ready = 1; In_ins = 32'hCAFEF00D; In_pc = 32'h20C;
    tick();
    Flush = 0; In_valid = 0; Out_ready = 0;
    vectors++; if (Count !== 0 || Out_valid !== 0) begin
      miscompares++; $display("FAIL flush_clear cnt=%0d ov=%b want 0/0", Count, Out_valid); end
    tick();
    vectors++; if (Out_valid !== 0 || Out_pc !== 0 || Imm_number !== 0) begin
      miscompares++; $display("FAIL flush_drop ov=%b pc=%h imm=%h want 0/0/0", Out_valid, Out_pc, Imm_number); end
  endtask

  task automatic test_empty_latency();
    In_valid = 1; In_ins = 32'h0; In_pc = 32'h40;
    #1;
    vectors++; if (Out_valid !== 0) begin
      miscompares++; $display("FAIL lat_push_cycle ov=%b want 0", Out_valid); end
    tick();
    In_valid = 0;
    vectors++; if (Out_valid !== 1 || Out_pc !== 32'h40 || Count !== 1) begin
      miscompares++; $display("FAIL lat_next ov=%b pc=%h cnt=%0d want 1/40/1", Out_valid, Out_pc, Count); end
    Out_ready = 1; tick(); Out_ready = 0;
  endtask

  task automatic test_random();
    logic [31:0] hw, hp;
    for (int i = 0; i < 300; i++) begin
      In_valid  = ($urandom_range(0, 3) != 0);
      Out_ready = ($urandom_range(0, 2) != 0);
      Flush     = ($urandom_range(0, 31) == 0);
      In_ins    = $urandom;
      In_pc     = $urandom;
      tick();
      hw = (q.size() > 0) ? q[0][31:0] : 32'h0;
      hp = (q.size() > 0) ? q[0][63:32] : 32'h0;
      vectors++; if (int'(Count) != q.size() || Out_valid !== (q.size() > 0) ||
                     In_ready !== (q.size() < DEPTH) || Out_pc !== hp ||
                     Op_code !== hw[31:26] || Rs_reg !== hw[25:21] || Rt_reg !== hw[20:16] ||
                     Rd_reg !== hw[15:11] || Sa_number !== hw[10:6] || Funct !== hw[5:0] ||
                     Imm_number !== hw[15:0] || Jump_target !== hw[25:0]) begin
        miscompares++; $display("FAIL rand_%0d cnt=%0d ov=%b ir=%b pc=%h op=%h imm=%h want cnt=%0d pc=%h word=%h",
                                i, Count, Out_valid, In_ready, Out_pc, Op_code, Imm_number, q.size(), hp, hw); end
    end
    In_valid = 0; Out_ready = 0; Flush = 0;
  endtask

  initial begin
    test_reset();
    test_fill_decode();
    test_drain();
    test_back_to_back();
    test_flush();
    test_empty_latency();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ir_fetch_queue.md
Name: ir_fetch_queue

Overview:
- Parametrised successor to the single-entry instruction register.
- Buffers up to DEPTH fetched instruction words, each with its fetch PC, in a FIFO with valid/ready handshakes on both sides.
- Exposes the MIPS-style decoded fields of the head entry to the control unit and datapath.
- Sits between instruction memory and the decode/control stage, decoupling fetch from execute; supports a flush for taken branches and jumps.

Parameters:
- DEPTH, 4: number of queue entries; power of two, 2..16.
- PC_W, 32: width of the PC stored alongside each instruction.
- CNT_W, $clog2(DEPTH)+1: derived count width; not overridden by instantiators.

Ports:
- CLK  in  1: single clock; all state updates on posedge CLK.
- Reset  in  1: asynchronous, active-high; clears the queue.
- Flush  in  1: synchronous discard of all entries.
- In_valid  in  1: fetch side offers a word.
- In_ready  out  1: queue can accept; equals !full.
- In_ins  in  32: instruction word.
- In_pc  in  PC_W: PC of In_ins.
- Out_valid  out  1: head entry present; equals !empty.
- Out_ready  in  1: decode consumes the head.
- Out_pc  out  PC_W: PC of the head entry.
- Op_code  out  6: head[31:26].
- Rs_reg  out  5: head[25:21].
- Rt_reg  out  5: head[20:16].
- Rd_reg  out  5: head[15:11].
- Sa_number  out  5: head[10:6].
- Funct  out  6: head[5:0].
- Imm_number  out  16: head[15:0].
- Jump_target  out  26: head[25:0].
- Count  out  CNT_W: number of valid entries, 0..DEPTH.

Behaviour:
- Storage: DEPTH x (32+PC_W) array, read pointer rd_ptr, write pointer wr_ptr, count cnt.
- Pointer widths are log2(DEPTH); pointers wrap modulo DEPTH naturally.
- Reset asserted, at any time and also mid-transfer:
  - rd_ptr, wr_ptr and cnt go to 0 immediately.
  - Out_valid=0, In_ready=1, Count=0.
  - All field outputs and Out_pc read 0.
  - Array contents need not be cleared.
- Push: occurs when In_valid && In_ready at posedge. The entry is written at wr_ptr, then wr_ptr+1.
- Pop: occurs when Out_valid && Out_ready at posedge. Then rd_ptr+1.
- Count update:
  - cnt+1 on push only.
  - cnt-1 on pop only.
  - Unchanged on simultaneous push and pop.
- Full: push is refused because In_ready=0, even if a pop occurs in the same cycle. There is no full pass-through.
- Empty: Out_valid=0; Out_ready is ignored.
  - No bypass: a word pushed into an empty queue appears on the outputs the cycle after the push edge.
  - Latency is one cycle.
- Flush: highest synchronous priority.
  - At the posedge with Flush=1: rd_ptr=wr_ptr=0 and cnt=0.
  - Any simultaneous push or pop is discarded.
  - In_ready is still 1 during the Flush cycle unless full; the word offered that cycle is dropped.
  - The fetch side treats Flush as overriding its own handshake.
- Outputs:
  - Decoded fields and Out_pc are combinational slices of entry[rd_ptr].
  - They are forced to 0 when empty, so no stale instruction is visible.
  - They are stable while the head is not popped.
- Simultaneous push and pop with cnt==1: the old head leaves, and the new word becomes head next cycle. Out_valid stays 1.
- No overflow or underflow is possible by construction. The bench asserts cnt<=DEPTH.

Decomposition:
- Shared package mips_ins_pkg holds:
  - field bit-position constants: OP_HI=31, RS_HI=25, RT_HI=20, RD_HI=15, SA_HI=10, FUNCT_HI=5, IMM_W=16, JT_W=26;
  - INS_W=32.
- One sub-module, ins_field_split: combinational 32-bit word to the fields above, with a zero-gate input. It is reusable by the decoder and the debug tap.
- FIFO pointers and count stay in ir_fetch_queue.

Test Plan:
- Reset mid-operation: push 0x8C220004 and 0x00430820, then raise Reset between clock edges -> Count=0, Out_valid=0, Op_code=0 immediately without waiting for a clock edge; In_ready=1.
- Fill and decode, DEPTH=4: push 0x8C220004 @PC 0x0, then 0x00430820, 0x08000010, 0x20010005 with Out_ready=0 -> In_ready=0 after the 4th push, Count=4.
  - Head checks: Op_code=0x23, Rs=1, Rt=2, Imm=0x0004, Out_pc=0.
  - A 5th push offered while full is refused; Count stays 4.
- Drain order: raise Out_ready -> heads in order:
  - 0x00430820: Rd=1, Funct=0x20;
  - 0x08000010: Jump_target=0x0000010;
  - 0x20010005: Op_code=0x08.
  - After the last pop: Out_valid=0, fields read 0, Count=0.
- Simultaneous push/pop at Count=1 over 20 cycles with an incrementing word -> Count stays 1; each head equals the word pushed one cycle earlier. Wrap-around is exercised at least 4 times.
- Flush with concurrent push and pop at Count=3 -> next cycle Count=0, Out_valid=0; the pushed word never appears on the outputs.
- Empty latency: push 0x00000000 @PC 0x40 into an empty queue -> Out_valid=1 exactly one cycle later with Out_pc=0x40. Out_valid=0 in the push cycle itself.
